// File: rtl/adapter_in_high_perf_pkg.sv
// Shared Dilithium adapter package.
// Holds the command mode encoding, the adapter FSM state enum and the
// fixed-part length table (words) per mode / security level, plus the
// lookup helper that turns a latched mode/level into that length.
package adapter_in_high_perf_pkg;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'd0,
        MODE_SIGN    = 2'd1,
        MODE_VERIFY  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIXED = 3'd1,
        S_MSG   = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [10:0] LEN_KEYGEN    = 11'd4;
    localparam logic [10:0] LEN_SIGN_L2   = 11'd316;
    localparam logic [10:0] LEN_SIGN_L3   = 11'd500;
    localparam logic [10:0] LEN_SIGN_L5   = 11'd608;
    localparam logic [10:0] LEN_VERIFY_L2 = 11'd467;
    localparam logic [10:0] LEN_VERIFY_L3 = 11'd656;
    localparam logic [10:0] LEN_VERIFY_L5 = 11'd899;

    // Any security level other than 2 or 3 selects the level-5 length.
    function automatic logic [10:0] fixed_len_words(input mode_t m, input logic [2:0] lvl);
        logic [10:0] len;
        len = LEN_KEYGEN;
        case (m)
            MODE_SIGN: begin
                case (lvl)
                    3'd2:    len = LEN_SIGN_L2;
                    3'd3:    len = LEN_SIGN_L3;
                    default: len = LEN_SIGN_L5;
                endcase
            end
            MODE_VERIFY: begin
                case (lvl)
                    3'd2:    len = LEN_VERIFY_L2;
                    3'd3:    len = LEN_VERIFY_L3;
                    default: len = LEN_VERIFY_L5;
                endcase
            end
            default: len = LEN_KEYGEN;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/adapter_in_high_perf_fifo_buffer.sv
// fifo_buffer: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write request and word; ignored when full
//   pop             read request; ignored when empty
//   head            word at the head of the FIFO (valid when !empty)
//   full, empty     occupancy flags
module fifo_buffer #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and is never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adapter_in_high_perf.sv
// adapter_in_high_perf: framing adapter between an external word stream and
// the Dilithium core. Checks that the stream has the fixed-part length
// implied by mode/sec_lvl, buffers words through an elastic FIFO and flags
// framing errors.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, mode, sec_lvl     one-cycle start pulse with latched command
//   valid_i/ready_i/data_i/last_i                      source stream
//   dilithium_valid_i/_ready_i/_data_i/_last_i         stream into core
//   done                     pulse when the final word is taken by the core
//   error                    sticky framing error (cleared by rst or start)
module adapter_in_high_perf
    import adapter_in_high_perf_pkg::*;
#(
    parameter int W          = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [2:0]   sec_lvl,
    input  logic         valid_i,
    output logic         ready_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    output logic         dilithium_valid_i,
    input  logic         dilithium_ready_i,
    output logic [W-1:0] dilithium_data_i,
    output logic         dilithium_last_i,
    output logic         done,
    output logic         error
);
    state_t      state;
    state_t      state_nxt;
    mode_t       mode_q;
    logic [2:0]  lvl_q;
    logic [10:0] cnt;
    logic [10:0] word_num;
    logic [10:0] fixed_len;
    logic        accept;
    logic        pop;
    logic        push;
    logic        cnt_inc;
    logic        fifo_rst;
    logic        fifo_full;
    logic        fifo_empty;
    logic [W:0]  head;

    assign fixed_len = fixed_len_words(mode_q, lvl_q);
    assign word_num  = cnt + 11'd1;

    // A start cycle never accepts a word: the presented word is dropped.
    assign ready_i = ((state == S_FIXED) || (state == S_MSG)) && !fifo_full && !start;
    assign accept  = valid_i && ready_i;

    assign dilithium_valid_i = !fifo_empty;
    assign pop               = dilithium_valid_i && dilithium_ready_i;
    assign dilithium_data_i  = head[W-1:0];
    assign dilithium_last_i  = head[W] && !fifo_empty;

    assign error    = (state == S_ERR);
    // The FIFO is held empty for the whole error state and flushed by start.
    assign fifo_rst = rst || start || (state == S_ERR);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        cnt_inc   = 1'b0;
        done      = 1'b0;
        case (state)
            S_FIXED: begin
                if (accept) begin
                    if (word_num == fixed_len) begin
                        // Keygen has no message part: its last fixed word must end the frame.
                        if (mode_q == MODE_KEYGEN && !last_i) begin
                            state_nxt = S_ERR;
                        end else begin
                            push      = 1'b1;
                            cnt_inc   = 1'b1;
                            state_nxt = last_i ? S_DRAIN : S_MSG;
                        end
                    end else if (last_i) begin
                        // Short frame: drop the word and fail.
                        state_nxt = S_ERR;
                    end else begin
                        push    = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_MSG: begin
                if (accept) begin
                    push = 1'b1;
                    if (last_i) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head[W]) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase
        if (start) begin
            state_nxt = (mode_t'(mode) == MODE_ILLEGAL) ? S_ERR : S_FIXED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= MODE_KEYGEN;
            lvl_q  <= 3'd0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                mode_q <= mode_t'(mode);
                lvl_q  <= sec_lvl;
                cnt    <= '0;
            end else if (cnt_inc) begin
                cnt <= word_num;
            end
        end
    end

    fifo_buffer #(
        .WIDTH (W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (fifo_rst),
        .push      (push),
        .push_data ({last_i, data_i}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/adapter_in_high_perf.md
ADAPTER_IN_HIGH_PERF -- requirements
Module: adapter_in_high_perf

Interface
REQ-001 SHALL have parameter W, default 64, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, input elastic buffer depth in words.
REQ-003 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have start  input  1  one-cycle pulse; latches mode/sec_lvl and begins a transfer.
REQ-006 SHALL have mode  input  2  0 keygen, 1 sign, 2 verify, 3 illegal.
REQ-007 SHALL have sec_lvl  input  3  2, 3 or 5 (any other value treated as 5).
REQ-008 SHALL have valid_i / ready_i / data_i / last_i  input/output/input[W]/input  external source stream; last_i marks final word.
REQ-009 SHALL have dilithium_valid_i / dilithium_ready_i / dilithium_data_i / dilithium_last_i  output/input/output[W]/output  stream into core.
REQ-010 SHALL have done  output  1  one-cycle pulse when the final word is accepted by the core.
REQ-011 SHALL have error  output  1  sticky framing-error flag, cleared by rst or start.

Function
REQ-012 SHALL implement FSM IDLE -> FIXED -> MSG -> DRAIN -> IDLE, plus ERR; start from any state enters FIXED (mode 3 enters ERR).
REQ-013 SHALL take fixed-part length L (words) from latched mode/sec_lvl: keygen 4; sign 316/500/608; verify 467/656/899 (lvl 2/3/5).
REQ-014 SHALL drive ready_i = (state FIXED or MSG) and FIFO not full and not start; a word transfers when valid_i && ready_i.
REQ-015 SHALL count accepted words in FIXED with an 11-bit counter cleared on start.
REQ-016 SHALL, in keygen, require last_i exactly on word 4; word 4 with last_i -> DRAIN; word 4 without last_i -> ERR.
REQ-017 SHALL, in sign/verify, on word L move to MSG, or to DRAIN if last_i is set on word L (zero-length message).
REQ-018 SHALL, in MSG, accept unbounded words and move to DRAIN on the word carrying last_i.
REQ-019 SHALL enter ERR when last_i accompanies an accepted word with count < L; that word is discarded (not written to FIFO).
REQ-020 SHALL store each accepted word with its last flag (W+1 bits) in the FIFO; dilithium_valid_i = FIFO not empty, dilithium_data_i/dilithium_last_i = FIFO head.
REQ-021 SHALL pop the FIFO when dilithium_valid_i && dilithium_ready_i; simultaneous push and pop leaves occupancy unchanged.
REQ-022 SHALL, in DRAIN, pulse done and return to IDLE in the cycle the word with last flag is popped.
REQ-023 SHALL, in ERR, hold ready_i low, flush the FIFO, assert error, and stay until start or rst.
REQ-024 SHALL, on start mid-transfer, flush FIFO, clear counter and error, and discard any word presented that cycle.
REQ-025 SHALL add no latency beyond one cycle: word accepted at cycle n visible at dilithium_data_i at n+1 when FIFO was empty.

Reset
REQ-026 SHALL, on rst, enter IDLE, empty FIFO, clear counter, and drive ready_i=0, dilithium_valid_i=0, dilithium_last_i=0, done=0, error=0.
REQ-027 SHALL give rst priority over start in the same cycle.

Structure
REQ-028 SHALL place the mode encoding, state enum and fixed-length table constants in the shared Dilithium adapter package.
REQ-029 SHALL instantiate the codebase fifo_buffer (WIDTH=W+1, DEPTH=FIFO_DEPTH) as its only sub-module, its reset driven by rst, start or ERR.

Verification
REQ-030 Keygen: start mode 0, 4 words, last_i on word 4, core ready -> 4 words out, dilithium_last_i on word 4, done one pulse, error 0.
REQ-031 Sign lvl 2: 316 fixed + 3 message words, last on 319, core ready toggling 50% -> all 319 in order, done once.
REQ-032 Verify lvl 3: last_i on word 100 -> error 1, ready_i 0, nothing after word 99 reaches core; next start clears error.
REQ-033 Backpressure: core ready low for 40 cycles, depth 16 -> ready_i drops after 16 words, no loss or duplication on release.
REQ-034 Sign lvl 5: last_i on word 608 -> zero-length message, done after word 608; start asserted at word 50 of a prior transfer -> FIFO flushed, new transfer clean.
REQ-035 Mode 3 start -> error 1 next cycle, ready_i stays 0.
